// File: rtl/bus_responder_mem_pkg.sv
// Shared encodings for the bus responder: FSM states, RW codes and default depth.
package bus_responder_mem_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RESP_LECT = 2'd1,
    RESP_ERR  = 2'd2
  } estado_t;

  localparam logic LECTURA   = 1'b0;
  localparam logic ESCRITURA = 1'b1;

  localparam int PROF_DEF = 16;

endpackage

// File: rtl/bus_responder_mem_if.sv
// Bus between master and responder: request strobe, address, data and RW in; read data, flags and write count out.
// One request per cycle, no backpressure; responses are single-cycle pulses.
interface bus_responder_mem_if;

  logic       i_valido;
  logic [7:0] i_direccion_datos;
  logic [7:0] i_entrada_datos;
  logic       RW;
  logic [7:0] o_dato_leido;
  logic       o_dato_valido;
  logic       o_fuera_rango;
  logic [7:0] o_escrituras;

  modport master (
    output i_valido, i_direccion_datos, i_entrada_datos, RW,
    input  o_dato_leido, o_dato_valido, o_fuera_rango, o_escrituras
  );

  modport slave (
    input  i_valido, i_direccion_datos, i_entrada_datos, RW,
    output o_dato_leido, o_dato_valido, o_fuera_rango, o_escrituras
  );

endinterface

// File: rtl/bus_responder_mem_contador_sat.sv
// 8-bit counter with enable that sticks at 0xFF; updates on the enabling edge.
// No backpressure: counts every enabled cycle until saturated.
module contador_sat (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  output logic [7:0] o_cuenta
);

  logic [7:0] r_cuenta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cuenta <= 8'h00;
    end else if (i_en && (r_cuenta != 8'hFF)) begin
      r_cuenta <= r_cuenta + 8'd1;
    end
  end

  assign o_cuenta = r_cuenta;

endmodule

// File: rtl/bus_responder_mem.sv
// Register-file bus responder: writes commit at the sampling edge, reads answer 1 cycle later.
// No backpressure: a request may be sampled every cycle; out-of-range accesses flag o_fuera_rango.
module bus_responder_mem
  import bus_responder_mem_pkg::*;
#(
  parameter int PROF = PROF_DEF
) (
  input  logic                clk,
  input  logic                rst,
  bus_responder_mem_if.slave  bus
);

  localparam int         AW     = (PROF > 1) ? $clog2(PROF) : 1;
  localparam logic [8:0] PROF_L = 9'(PROF);

  logic [7:0]    r_mem [PROF];
  estado_t       r_estado;
  logic [7:0]    r_dato_leido;
  logic          r_dato_valido;
  logic          r_fuera_rango;

  logic          w_en_rango;
  logic          w_escr;
  logic [AW-1:0] w_idx;

  assign w_en_rango = ({1'b0, bus.i_direccion_datos} < PROF_L);
  assign w_idx      = bus.i_direccion_datos[AW-1:0];
  // i_valido gates RW first so an undriven RW on idle cycles cannot leak in
  assign w_escr     = bus.i_valido && (bus.RW == ESCRITURA) && w_en_rango;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PROF; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else if (w_escr) begin
      r_mem[w_idx] <= bus.i_entrada_datos;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_estado      <= IDLE;
      r_dato_leido  <= 8'h00;
      r_dato_valido <= 1'b0;
      r_fuera_rango <= 1'b0;
    end else begin
      case (r_estado)
        RESP_LECT, RESP_ERR: begin
          r_dato_valido <= 1'b0;
          r_fuera_rango <= 1'b0;
        end
        default: ;
      endcase
      r_estado <= IDLE;
      if (bus.i_valido) begin
        if (!w_en_rango) begin
          r_estado      <= RESP_ERR;
          r_fuera_rango <= 1'b1;
          if (bus.RW == LECTURA) begin
            r_dato_leido  <= 8'h00;
            r_dato_valido <= 1'b1;
          end
        end else if (bus.RW == LECTURA) begin
          r_estado      <= RESP_LECT;
          r_dato_leido  <= r_mem[w_idx];
          r_dato_valido <= 1'b1;
        end
      end
    end
  end

  contador_sat u_contador (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_escr),
    .o_cuenta (bus.o_escrituras)
  );

  assign bus.o_dato_leido  = r_dato_leido;
  assign bus.o_dato_valido = r_dato_valido;
  assign bus.o_fuera_rango = r_fuera_rango;

endmodule

// File: tb/tb_bus_responder_mem.sv
// Directed bench for bus_responder_mem with a per-cycle expected-response queue.
module tb_bus_responder_mem;

  logic clk;
  logic rst;
  int   checks;
  int   errores;

  typedef struct {
    logic       vld;
    logic       fr;
    logic [7:0] dato;
    logic [7:0] esc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m [16];
  logic [7:0] cnt;
  logic [7:0] last;

  bus_responder_mem_if bus_if ();

  bus_responder_mem #(.PROF(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errores++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic modelo_reset();
    for (int i = 0; i < 16; i++) m[i] = 8'h00;
    cnt  = 8'h00;
    last = 8'h00;
  endtask

  // Drive one cycle, queue its expected response, then compare after the edge.
  task automatic op(input string tag, input logic v, input logic rw,
                    input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    bus_if.i_valido          = v;
    bus_if.RW                = v ? rw : 1'bx;
    bus_if.i_direccion_datos = v ? a : 8'hxx;
    bus_if.i_entrada_datos   = d;
    e.vld = 1'b0;
    e.fr  = 1'b0;
    if (v) begin
      if (a < 8'd16) begin
        if (rw) begin
          m[a[3:0]] = d;
          if (cnt != 8'hFF) cnt = cnt + 8'd1;
        end else begin
          e.vld = 1'b1;
          last  = m[a[3:0]];
        end
      end else begin
        e.fr = 1'b1;
        if (!rw) begin
          e.vld = 1'b1;
          last  = 8'h00;
        end
      end
    end
    e.dato = last;
    e.esc  = cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, "_vld"},  {7'd0, bus_if.o_dato_valido}, {7'd0, e.vld});
    chk({tag, "_fr"},   {7'd0, bus_if.o_fuera_rango}, {7'd0, e.fr});
    chk({tag, "_dato"}, bus_if.o_dato_leido, e.dato);
    chk({tag, "_esc"},  bus_if.o_escrituras, e.esc);
  endtask

  initial begin
    checks  = 0;
    errores = 0;
    clk     = 1'b0;
    rst     = 1'b0;
    bus_if.i_valido          = 1'b0;
    bus_if.RW                = 1'b0;
    bus_if.i_direccion_datos = 8'h00;
    bus_if.i_entrada_datos   = 8'h00;
    modelo_reset();

    #3;
    chk("rst0_vld",  {7'd0, bus_if.o_dato_valido}, 8'h00);
    chk("rst0_fr",   {7'd0, bus_if.o_fuera_rango}, 8'h00);
    chk("rst0_dato", bus_if.o_dato_leido, 8'h00);
    chk("rst0_esc",  bus_if.o_escrituras, 8'h00);

    #9 rst = 1'b1;
    for (int i = 0; i < 3; i++) op("idle", 1'b0, 1'b0, 8'h00, 8'h00);

    op("wr03", 1'b1, 1'b1, 8'h03, 8'hA5);
    op("rd03", 1'b1, 1'b0, 8'h03, 8'h00);
    op("post03", 1'b0, 1'b0, 8'h00, 8'h00);

    op("wr00", 1'b1, 1'b1, 8'h00, 8'h11);
    op("wr01", 1'b1, 1'b1, 8'h01, 8'h22);
    op("wr02", 1'b1, 1'b1, 8'h02, 8'h33);
    op("rd00", 1'b1, 1'b0, 8'h00, 8'h00);
    op("rd01", 1'b1, 1'b0, 8'h01, 8'h00);
    op("rd02", 1'b1, 1'b0, 8'h02, 8'h00);
    op("hold", 1'b0, 1'b0, 8'h00, 8'h00);

    op("wr20", 1'b1, 1'b1, 8'h20, 8'h7E);
    op("rd20", 1'b1, 1'b0, 8'h20, 8'h00);
    op("rd10", 1'b1, 1'b0, 8'h10, 8'h00);
    op("rd0f", 1'b1, 1'b0, 8'h0F, 8'h00);

    for (int i = 0; i < 260; i++) op("wr05", 1'b1, 1'b1, 8'h05, 8'(i + 3));
    op("rd05", 1'b1, 1'b0, 8'h05, 8'h00);

    op("wr0f", 1'b1, 1'b1, 8'h0F, 8'h5A);
    bus_if.i_valido          = 1'b1;
    bus_if.RW                = 1'b0;
    bus_if.i_direccion_datos = 8'h0F;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    modelo_reset();
    chk("arst_vld",  {7'd0, bus_if.o_dato_valido}, 8'h00);
    chk("arst_fr",   {7'd0, bus_if.o_fuera_rango}, 8'h00);
    chk("arst_dato", bus_if.o_dato_leido, 8'h00);
    chk("arst_esc",  bus_if.o_escrituras, 8'h00);
    bus_if.i_valido = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) op("relidle", 1'b0, 1'b0, 8'h00, 8'h00);
    op("rd0f_rst", 1'b1, 1'b0, 8'h0F, 8'h00);
    op("end", 1'b0, 1'b0, 8'h00, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errores);
    $finish;
  end

endmodule

// File: doc/bus_responder_mem.md
BUS_RESPONDER_MEM -- requirements
Module: bus_responder_mem

Interface
REQ-001 The block SHALL have exactly one clock and one reset: clock is clk, reset is rst, and rst is asynchronous and active-low.
REQ-002 The ports SHALL be, one per line (name  direction  width  meaning):
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- i_valido  input  1  bus access strobe; 1 = request present this cycle.
- i_direccion_datos  input  8  access address from bus master.
- i_entrada_datos  input  8  write data from bus master.
- RW  input  1  1 = write, 0 = read.
- o_dato_leido  output  8  read data.
- o_dato_valido  output  1  read data valid, one-cycle pulse per read.
- o_fuera_rango  output  1  one-cycle pulse, access address > 0x0F.
- o_escrituras  output  8  count of committed writes, saturating.
REQ-003 The parameter SHALL be PROF, default 16, meaning memory depth in 8-bit words (address space 0x00..PROF-1).

Function
REQ-004 Storage SHALL be PROF x 8-bit registers addressed by i_direccion_datos.
REQ-005 A request SHALL be sampled at the rising clk edge when i_valido=1; i_valido=0 SHALL be an idle cycle, with all other inputs ignored.
REQ-006 In-range write (RW=1): at the sampling edge, mem[addr] <= i_entrada_datos and o_escrituras increments by 1, saturating at 0xFF.
REQ-007 In-range read (RW=0): at the sampling edge, o_dato_leido <= mem[addr] and o_dato_valido <= 1, giving a latency of 1 cycle.
REQ-008 o_dato_valido SHALL be 0 in every cycle following an edge that sampled no read; o_dato_leido SHALL hold its last value while o_dato_valido=0.
REQ-009 Back-to-back reads SHALL produce back-to-back valid pulses, one per request, in order.
REQ-010 A read of an address written on the immediately preceding edge SHALL return the new data; no forwarding path is needed because writes commit at the sampling edge.
REQ-011 Out-of-range access (addr >= PROF): the write is discarded and the counter is unchanged; a read returns o_dato_leido=0x00 with o_dato_valido=1; o_fuera_rango=1 for exactly one cycle in both cases.
REQ-012 The internal FSM SHALL have states IDLE, RESP_LECT and RESP_ERR.
- IDLE goes to RESP_LECT on an in-range read, and to RESP_ERR on an out-of-range access.
- Each of these states returns to IDLE after one cycle, or re-enters according to the next sampled request.
- Outputs SHALL be registered, not decoded combinationally from the state.
REQ-013 RW SHALL be evaluated only when i_valido=1; no X on RW SHALL propagate while i_valido=0.

Reset
REQ-014 With rst=0, the block SHALL immediately (asynchronously) clear the following: all memory words to 0x00, o_dato_leido=0x00, o_dato_valido=0, o_fuera_rango=0, o_escrituras=0x00, FSM=IDLE.
REQ-015 A reset asserted mid-operation SHALL abort any pending response, and no valid pulse SHALL appear after reset release until a new read is sampled.
REQ-016 The first request SHALL be sampled on the first rising clk edge with rst=1.

Structure
REQ-017 A shared package SHALL hold the FSM state encoding (IDLE, RESP_LECT, RESP_ERR), the RW encodings (LECTURA=0, ESCRITURA=1) and the default depth constant 16.
REQ-018 A sub-module contador_sat (8-bit saturating counter with enable) SHALL implement o_escrituras; all other logic SHALL stay in bus_responder_mem.

Verification
REQ-019 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Reset release then idle 3 cycles -> all outputs 0, o_dato_valido never 1.
- Write 0xA5 to 0x03, next cycle read 0x03 -> o_dato_leido=0xA5 with o_dato_valido=1 one cycle after the read edge, and o_escrituras=1.
- Reads to 0x00, 0x01, 0x02 on consecutive cycles after writing 0x11, 0x22, 0x33 -> three consecutive valid pulses carrying 0x11, 0x22, 0x33.
- Write 0x7E to 0x20, then read 0x20 -> two o_fuera_rango pulses, read data 0x00, o_escrituras unchanged.
- 260 writes to 0x05 -> o_escrituras=0xFF and mem[0x05] equals the last data written.
- Write 0x5A to 0x0F, assert rst mid-read of 0x0F, release -> read 0x0F returns 0x00, and no valid pulse appears between release and the new read.
